// File: rtl/bus_master_arbiter.sv
// Two-master round-robin arbiter for the shared 8-bit peripheral bus, with a one-cycle park between owners.
// Optional hold-time preemption is compiled in by defining BUS_ARB_PREEMPT_EN.
module bus_master_arbiter #(
  parameter logic [7:0]  PARK_ADDR = 8'hFF,
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       M0_REQ,
  input  logic       M1_REQ,
  output logic       M0_GNT,
  output logic       M1_GNT,
  input  logic [7:0] M0_ADDR,
  input  logic [7:0] M1_ADDR,
  input  logic       M0_WE,
  input  logic       M1_WE,
  input  logic [7:0] M0_WDATA,
  input  logic [7:0] M1_WDATA,
  output logic [7:0] RDATA,
  output logic       M0_RVALID,
  output logic       M1_RVALID,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_PARK = 2'd3;
  localparam int NUM_M  = 2;
  localparam int STAGES = 2;

  logic [NUM_M-1:0]      req;
  logic [NUM_M-1:0]      m_we;
  logic [NUM_M-1:0][7:0] m_addr;
  logic [NUM_M-1:0][7:0] m_wdata;

  assign req     = {M1_REQ, M0_REQ};
  assign m_we    = {M1_WE, M0_WE};
  assign m_addr  = {M1_ADDR, M0_ADDR};
  assign m_wdata = {M1_WDATA, M0_WDATA};

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic             own, sel, preempt;

  assign own = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign sel = (state_q == ST_OWN1);

`ifdef BUS_ARB_PREEMPT_EN
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Counter sits at zero whenever nobody owns, so the first owned cycle sees 0.
  always_comb begin
    hold_cnt_d = '0;
    if (own) hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end

  assign preempt = own && (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) && req[~sel];
`else
  assign preempt = 1'b0;
  wire unused_hold_cfg = MAX_HOLD[0] ^ CNT_W[0];
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      ST_OWN0, ST_OWN1: begin
        if (!req[sel] || preempt) begin
          state_d = ST_PARK;
          prio_d  = ~sel;
        end
      end
      default: begin
        if (&req)        state_d = prio_q ? ST_OWN1 : ST_OWN0;
        else if (req[0]) state_d = ST_OWN0;
        else if (req[1]) state_d = ST_OWN1;
        else             state_d = ST_IDLE;
      end
    endcase
    gnt_d = {state_d == ST_OWN1, state_d == ST_OWN0};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  assign M0_GNT = gnt_q[0];
  assign M1_GNT = gnt_q[1];

  // Bus follows the owner combinationally; reset parks it through state_q.
  assign BUS_ADDR = own ? m_addr[sel] : PARK_ADDR;
  assign BUS_WE   = own & m_we[sel];
  assign BUS_DATA = BUS_WE ? m_wdata[sel] : 8'hzz;

  // Read pipe: stage 1 holds the tag while the peripheral's registered driver
  // answers, stage 2 captures BUS_DATA and pulses RVALID for that tag.
  logic              rd_issue;
  logic [STAGES:1]   vld_pipe_q;
  logic [STAGES:1]   tag_pipe_q;
  logic [7:0]        rdata_q;

  assign rd_issue = own & ~m_we[sel];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      rdata_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_issue};
      tag_pipe_q <= {tag_pipe_q[STAGES-1:1], sel};
      if (vld_pipe_q[STAGES-1]) rdata_q <= BUS_DATA;
    end
  end

  assign RDATA     = rdata_q;
  assign M0_RVALID = vld_pipe_q[STAGES] & ~tag_pipe_q[STAGES];
  assign M1_RVALID = vld_pipe_q[STAGES] &  tag_pipe_q[STAGES];

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: registered-tristate peripheral model at 0xC0-0xC3,
// read results checked against a scoreboard of expected {tag, data}.
module tb_bus_master_arbiter;
  logic       CLK = 1'b0;
  logic       RESET;
  logic       M0_REQ, M1_REQ;
  logic       M0_GNT, M1_GNT;
  logic [7:0] M0_ADDR, M1_ADDR;
  logic       M0_WE, M1_WE;
  logic [7:0] M0_WDATA, M1_WDATA;
  logic [7:0] RDATA;
  logic       M0_RVALID, M1_RVALID;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  wire  [7:0] BUS_DATA;

  always #5 CLK = ~CLK;

  bus_master_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .M0_REQ(M0_REQ), .M1_REQ(M1_REQ),
    .M0_GNT(M0_GNT), .M1_GNT(M1_GNT),
    .M0_ADDR(M0_ADDR), .M1_ADDR(M1_ADDR),
    .M0_WE(M0_WE), .M1_WE(M1_WE),
    .M0_WDATA(M0_WDATA), .M1_WDATA(M1_WDATA),
    .RDATA(RDATA), .M0_RVALID(M0_RVALID), .M1_RVALID(M1_RVALID),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA(BUS_DATA)
  );

  // Peripheral with a registered tristate read driver, decoding 0xC0-0xC3.
  logic [7:0] pmem [0:3];
  logic       per_drv;
  logic [7:0] per_dout;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) per_drv <= 1'b0;
    else begin
      per_drv  <= (BUS_ADDR[7:2] == 6'h30) && !BUS_WE;
      per_dout <= pmem[BUS_ADDR[1:0]];
      if ((BUS_ADDR[7:2] == 6'h30) && BUS_WE) pmem[BUS_ADDR[1:0]] <= BUS_DATA;
    end
  end
  assign BUS_DATA = per_drv ? per_dout : 8'hzz;

  typedef struct packed { logic tag; logic [7:0] data; } rd_t;
  rd_t sb[$];
  int  n_pass = 0;
  int  n_total = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic nxt(); @(posedge CLK); #1; endtask
  task automatic smp(); @(negedge CLK); endtask

  task automatic m0(input logic [7:0] a, input logic we, input logic [7:0] d);
    M0_ADDR = a; M0_WE = we; M0_WDATA = d;
  endtask
  task automatic m1(input logic [7:0] a, input logic we, input logic [7:0] d);
    M1_ADDR = a; M1_WE = we; M1_WDATA = d;
  endtask

  // Read-data monitor: every RVALID must match the oldest expected read.
  always @(negedge CLK) begin
    if (M0_RVALID || M1_RVALID) begin
      rd_t e;
      chk("sb_avail", 16'(sb.size() > 0), 16'd1);
      chk("rv_onehot", 16'(M0_RVALID & M1_RVALID), 16'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rv_tag", 16'(M1_RVALID), 16'(e.tag));
        chk("rdata", 16'(RDATA), 16'(e.data));
      end
    end
  end

  int cnt;

  initial begin
    RESET = 1'b0; M0_REQ = 1'b0; M1_REQ = 1'b0;
    m0(8'h10, 1'b1, 8'h00); m1(8'h10, 1'b1, 8'h00);

    // reset state
    smp();
    chk("rst_gnt0", 16'(M0_GNT), 16'd0);
    chk("rst_gnt1", 16'(M1_GNT), 16'd0);
    chk("rst_addr", 16'(BUS_ADDR), 16'h00FF);
    chk("rst_we", 16'(BUS_WE), 16'd0);
    chk("rst_rdata", 16'(RDATA), 16'd0);
    chk("rst_rv", 16'({M1_RVALID, M0_RVALID}), 16'd0);
    nxt(); RESET = 1'b1;
    nxt();

    // M0 alone: writes then a final read, then PARK
    M0_REQ = 1'b1; smp();
    chk("req_gnt0_lat", 16'(M0_GNT), 16'd0);
    nxt(); m0(8'hC0, 1'b1, 8'hA5); smp();
    chk("wr_gnt0", 16'(M0_GNT), 16'd1);
    chk("wr_gnt1", 16'(M1_GNT), 16'd0);
    chk("wr_addr", 16'(BUS_ADDR), 16'h00C0);
    chk("wr_we", 16'(BUS_WE), 16'd1);
    chk("wr_data", 16'(BUS_DATA), 16'h00A5);
    nxt(); m0(8'hC1, 1'b1, 8'h3C); smp();
    chk("wr_data2", 16'(BUS_DATA), 16'h003C);
    nxt(); m0(8'hC2, 1'b1, 8'h5A);
    nxt(); m0(8'hC0, 1'b0, 8'h00); M0_REQ = 1'b0; sb.push_back({1'b0, 8'hA5}); smp();
    chk("rd_gnt0", 16'(M0_GNT), 16'd1);
    chk("rd_we", 16'(BUS_WE), 16'd0);
    nxt(); m0(8'h10, 1'b1, 8'h00); smp();
    chk("park_gnt0", 16'(M0_GNT), 16'd0);
    chk("park_addr", 16'(BUS_ADDR), 16'h00FF);
    chk("park_we", 16'(BUS_WE), 16'd0);
    chk("park_busdata", 16'(BUS_DATA), 16'h00A5);
    nxt(); smp();
    chk("rv0_pulse", 16'(M0_RVALID), 16'd1);
    chk("rv1_quiet", 16'(M1_RVALID), 16'd0);
    nxt(); smp();
    chk("rv0_one_cycle", 16'(M0_RVALID), 16'd0);

    // reset mid-OWN0 with a read in flight
    nxt(); M0_REQ = 1'b1;
    nxt(); m0(8'hC0, 1'b0, 8'h00); smp();
    chk("pre_rst_gnt0", 16'(M0_GNT), 16'd1);
    nxt(); RESET = 1'b0; M0_REQ = 1'b0; m0(8'h10, 1'b1, 8'h00); smp();
    chk("midrst_gnt", 16'({M1_GNT, M0_GNT}), 16'd0);
    chk("midrst_addr", 16'(BUS_ADDR), 16'h00FF);
    chk("midrst_we", 16'(BUS_WE), 16'd0);
    nxt(); smp();
    chk("midrst_norv", 16'({M1_RVALID, M0_RVALID}), 16'd0);
    nxt(); RESET = 1'b1; smp();
    chk("postrst_idle", 16'({M1_GNT, M0_GNT}), 16'd0);

    // both request from IDLE after reset: M0 first, handover via one PARK
    nxt(); M0_REQ = 1'b1; M1_REQ = 1'b1; smp();
    chk("both_lat", 16'({M1_GNT, M0_GNT}), 16'd0);
    nxt(); m0(8'hC3, 1'b1, 8'h77); M0_REQ = 1'b0; smp();
    chk("both_first", 16'({M1_GNT, M0_GNT}), 16'b01);
    nxt(); m0(8'h10, 1'b1, 8'h00); smp();
    chk("handover_park_gnt", 16'({M1_GNT, M0_GNT}), 16'd0);
    chk("handover_park_addr", 16'(BUS_ADDR), 16'h00FF);
    // back-to-back reads by M1
    nxt(); m1(8'hC2, 1'b0, 8'h00); sb.push_back({1'b1, 8'h5A}); smp();
    chk("m1_gnt", 16'({M1_GNT, M0_GNT}), 16'b10);
    chk("m1_addr", 16'(BUS_ADDR), 16'h00C2);
    nxt(); m1(8'hC3, 1'b0, 8'h00); M1_REQ = 1'b0; sb.push_back({1'b1, 8'h77}); smp();
    chk("m1_addr2", 16'(BUS_ADDR), 16'h00C3);
    nxt(); m1(8'h10, 1'b1, 8'h00); smp();
    chk("b2b_rv_a", 16'(M1_RVALID), 16'd1);
    chk("b2b_data_a", 16'(RDATA), 16'h005A);
    nxt(); smp();
    chk("b2b_rv_b", 16'(M1_RVALID), 16'd1);
    chk("b2b_data_b", 16'(RDATA), 16'h0077);
    nxt(); smp();
    chk("b2b_rv_end", 16'({M1_RVALID, M0_RVALID}), 16'd0);

    // previous owner re-requests in PARK and loses to the other master
    nxt(); M1_REQ = 1'b1;
    nxt(); M1_REQ = 1'b0; M0_REQ = 1'b1; smp();
    chk("alt_m1_own", 16'({M1_GNT, M0_GNT}), 16'b10);
    nxt(); M1_REQ = 1'b1; smp();
    chk("alt_park", 16'({M1_GNT, M0_GNT}), 16'd0);
    nxt(); M0_REQ = 1'b0; smp();
    chk("alt_m0_wins", 16'({M1_GNT, M0_GNT}), 16'b01);
    nxt(); smp();
    chk("alt_park2", 16'({M1_GNT, M0_GNT}), 16'd0);
    nxt(); M1_REQ = 1'b0; smp();
    chk("alt_m1_again", 16'({M1_GNT, M0_GNT}), 16'b10);
    nxt(); nxt();

    // long hold by M0 with M1 requesting from cycle 3
    M0_REQ = 1'b1; cnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (i == 3) M1_REQ = 1'b1;
      smp();
      if (M0_GNT) cnt++;
      else if (cnt > 0) break;
      nxt();
    end
`ifdef BUS_ARB_PREEMPT_EN
    chk("hold_cycles", 16'(cnt), 16'd16);
    chk("preempt_park_gnt", 16'({M1_GNT, M0_GNT}), 16'd0);
    chk("preempt_park_addr", 16'(BUS_ADDR), 16'h00FF);
    nxt(); smp();
    chk("preempt_m1_gnt", 16'({M1_GNT, M0_GNT}), 16'b10);
    nxt(); M1_REQ = 1'b0;
    nxt(); smp();
    chk("preempt_park2", 16'({M1_GNT, M0_GNT}), 16'd0);
    nxt(); smp();
    chk("preempt_m0_back", 16'({M1_GNT, M0_GNT}), 16'b01);
    nxt(); M0_REQ = 1'b0;
    nxt(); nxt();
`else
    chk("hold_cycles", 16'(cnt), 16'd47);
    M0_REQ = 1'b0; smp();
    chk("hold_still_own", 16'(M0_GNT), 16'd1);
    nxt(); smp();
    chk("hold_park", 16'({M1_GNT, M0_GNT}), 16'd0);
    nxt(); smp();
    chk("hold_m1_gnt", 16'({M1_GNT, M0_GNT}), 16'b10);
    nxt(); M1_REQ = 1'b0;
    nxt(); nxt();
`endif

    smp();
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Two-master arbiter for the shared 8-bit peripheral bus (BUS_ADDR, BUS_DATA, BUS_WE). It sits between the CPU (master 0) and a second bus master (master 1, e.g. a DMA or LED pattern sequencer).
- Grants ownership round-robin and muxes the owner's address, write-enable and write data onto the bus.
- Inserts a one-cycle park between owners so that the registered tristate driver in each peripheral releases BUS_DATA cleanly.
- Captures read data and returns it to the master that issued the read.

Parameters:
- PARK_ADDR, 8'hFF: address driven when no master owns the bus; must decode to no peripheral.
- MAX_HOLD, 16: maximum consecutive owned cycles before forced release when the other master is requesting (used only with the optional feature).
- CNT_W, 5: width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous reset, active-low (0 = reset).
- M0_REQ, M1_REQ  in  1 each  bus request.
- M0_GNT, M1_GNT  out  1 each  grant, registered.
- M0_ADDR, M1_ADDR  in  8 each  master address.
- M0_WE, M1_WE  in  1 each  master write enable.
- M0_WDATA, M1_WDATA  in  8 each  master write data.
- RDATA  out  8  captured read data, shared by both masters.
- M0_RVALID, M1_RVALID  out  1 each  RDATA valid for that master, one-cycle pulse.
- BUS_ADDR  out  8  bus address.
- BUS_WE  out  1  bus write enable.
- BUS_DATA  inout  8  bus data.

Behaviour:
- States: IDLE, OWN0, OWN1, PARK. State, grants, priority pointer, hold counter and read pipeline are registered and cleared asynchronously by RESET=0.
- Reset values:
  - state=IDLE; M0_GNT=M1_GNT=0; prio=0 (M0 first).
  - BUS_ADDR=PARK_ADDR; BUS_WE=0; BUS_DATA=Z.
  - RDATA=8'h00; both RVALID=0; hold_cnt=0.
- Reset mid-operation: the bus parks and all grants drop immediately (asynchronously). Any pending read is discarded with no RVALID.
- Arbitration (from IDLE or PARK):
  - Both REQ high → the master selected by prio.
  - Otherwise the single requester.
  - No requester → IDLE.
- Entering OWNx: GNTx=1 from the following cycle; hold_cnt=0.
- OWNx:
  - BUS_ADDR=Mx_ADDR and BUS_WE=Mx_WE, combinational from the owner.
  - BUS_DATA=Mx_WDATA when Mx_WE=1, else Z.
  - hold_cnt increments and saturates.
- OWNx → PARK when Mx_REQ=0, or when the optional preemption triggers. On the transition: GNTx clears and prio points to the other master.
- Latency: grant one edge after REQ is seen in IDLE/PARK. Park is exactly one cycle. Back-to-back handover costs 1 idle bus cycle.
- PARK / IDLE: BUS_ADDR=PARK_ADDR, BUS_WE=0, BUS_DATA=Z.
- Reads, 2-stage pipeline:
  - At the edge ending a cycle with OWNx and Mx_WE=0, stage 1 records the tag x.
  - At the next edge, RDATA<=BUS_DATA and Mx_RVALID=1 for one cycle.
  - One read per cycle is sustainable.
  - A read issued in the last owned cycle completes during PARK; this is the purpose of the park cycle.
- Writes complete in the owned cycle; no acknowledge.
- Master rules: a master drives ADDR/WE/WDATA only while its GNT=1. It may drop REQ at any time; the arbiter releases at the next edge.
- Simultaneous events: in PARK both masters requesting → prio (the other master) wins, guaranteeing alternation.

Optional Feature:
- Macro BUS_ARB_PREEMPT_EN.
- Defined: in OWNx, if hold_cnt==MAX_HOLD-1 and the other REQ=1, transition to PARK. The preempted master loses GNT regardless of its REQ and is re-granted later by round-robin.
- Undefined: hold_cnt logic is removed; the owner keeps the bus while its REQ=1 (no starvation bound).

Test Plan:
- Reset: RESET=0 mid-OWN0 with a read pending → GNTs=0, BUS_ADDR=8'hFF, BUS_WE=0, no RVALID; release → IDLE.
- M0_REQ=1 alone, M0 writes 8'hA5 to 8'hC0 → M0_GNT high the next cycle; BUS_ADDR=8'hC0, BUS_WE=1, BUS_DATA=8'hA5 during that cycle.
- M0 reads 8'hC0 (peripheral holds 8'hA5) then drops REQ → BUS_DATA read 8'hA5 during PARK; RDATA=8'hA5 with M0_RVALID pulse, M1_RVALID=0.
- Both REQ high from IDLE after reset → M0 granted. M0 drops → 1 PARK cycle with BUS_ADDR=8'hFF, then M1_GNT=1.
- BUS_ARB_PREEMPT_EN, MAX_HOLD=16: M0 holds REQ, M1 requests at cycle 3 → M0_GNT falls after 16 owned cycles, PARK, M1_GNT=1. Without the macro, M0_GNT stays high indefinitely.
- Back-to-back reads from 8'hC0, 8'hC1 on consecutive cycles → RVALID high on two consecutive cycles with the two values in order.
